// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes,
// multi-cycle data-memory freeze with timeout trap, stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             branch_taken_i,
  input  logic             exmem_memaccess_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
  output logic             mem_req_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] ERROR    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              timeout_q, timeout_d;

  logic load_use;
  logic mem_stall;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_req;

  // Hazard detection terms
  assign load_use  = idex_memread_i & (idex_rt_i != 5'd0) &
                     ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));
  assign mem_stall = exmem_memaccess_i & ~mem_ack_i;

  // Next-state and Mealy output decode; reset overrides the outputs
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    mem_req     = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          mem_req    = 1'b1;
          pipe_hold  = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else if (load_use) begin
          // Branch in ID is held and re-evaluated once the bubble lands
          idex_bubble = 1'b1;
          mem_req     = exmem_memaccess_i;
        end else if (branch_taken_i) begin
          ifid_flush = 1'b1;
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          mem_req    = exmem_memaccess_i;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          mem_req    = exmem_memaccess_i;
        end
      end
      MEM_WAIT: begin
        // Front end stays frozen even on the ack cycle; only the back end moves
        mem_req = 1'b1;
        if (mem_ack_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          pipe_hold = 1'b1;
          if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_d = ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      ERROR: begin
        pipe_hold = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (!rst_i) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
      pipe_hold   = 1'b0;
      mem_req     = 1'b0;
    end
  end

  // Sticky timeout flag and saturating stall counter next values
  always_comb begin
    timeout_d   = timeout_q | (state_d == ERROR);
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pc_write_o    = pc_write;
  assign ifid_write_o  = ifid_write;
  assign ifid_flush_o  = ifid_flush;
  assign idex_bubble_o = idex_bubble;
  assign pipe_hold_o   = pipe_hold;
  assign mem_req_o     = mem_req;
  assign timeout_o     = timeout_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_hazard_stall_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMO   = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             idex_memread_i, branch_taken_i, exmem_memaccess_i, mem_ack_i;
  logic [4:0]       idex_rt_i, ifid_rs_i, ifid_rt_i;
  logic             pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o;
  logic             pipe_hold_o, mem_req_o, timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  hazard_stall_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .idex_memread_i    (idex_memread_i),
    .idex_rt_i         (idex_rt_i),
    .ifid_rs_i         (ifid_rs_i),
    .ifid_rt_i         (ifid_rt_i),
    .branch_taken_i    (branch_taken_i),
    .exmem_memaccess_i (exmem_memaccess_i),
    .mem_ack_i         (mem_ack_i),
    .pc_write_o        (pc_write_o),
    .ifid_write_o      (ifid_write_o),
    .ifid_flush_o      (ifid_flush_o),
    .idex_bubble_o     (idex_bubble_o),
    .pipe_hold_o       (pipe_hold_o),
    .mem_req_o         (mem_req_o),
    .timeout_o         (timeout_o),
    .stall_cnt_o       (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare all Mealy outputs: pc, ifid_write, flush, bubble, hold, req
  task automatic chk_out(input string tag, input logic pc, input logic ifw, input logic fl,
                         input logic bub, input logic hold, input logic req);
    check({tag, ".pc_write"},    32'(pc_write_o),    32'(pc));
    check({tag, ".ifid_write"},  32'(ifid_write_o),  32'(ifw));
    check({tag, ".ifid_flush"},  32'(ifid_flush_o),  32'(fl));
    check({tag, ".idex_bubble"}, 32'(idex_bubble_o), 32'(bub));
    check({tag, ".pipe_hold"},   32'(pipe_hold_o),   32'(hold));
    check({tag, ".mem_req"},     32'(mem_req_o),     32'(req));
  endtask

  task automatic drive(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                       input logic [4:0] frt, input logic br, input logic ma, input logic ack);
    idex_memread_i    = mr;
    idex_rt_i         = rt;
    ifid_rs_i         = rs;
    ifid_rt_i         = frt;
    branch_taken_i    = br;
    exmem_memaccess_i = ma;
    mem_ack_i         = ack;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b0;
    idle();
    #1;
    chk_out("rst", 0, 0, 0, 1, 0, 0);
    check("rst.timeout", 32'(timeout_o), 0);
    check("rst.cnt", 32'(stall_cnt_o), 0);

    @(negedge clk_i);
    rst_i = 1'b1;
    idle();
    chk_out("idle", 1, 1, 0, 0, 0, 0);
    @(negedge clk_i);
    check("idle.cnt", 32'(stall_cnt_o), 0);

    // Load-use on rs
    drive(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0);
    chk_out("lu", 0, 0, 0, 1, 0, 0);
    @(negedge clk_i);
    check("lu.cnt", 32'(stall_cnt_o), 1);
    idle();
    chk_out("lu_clear", 1, 1, 0, 0, 0, 0);
    @(negedge clk_i);
    check("lu_clear.cnt", 32'(stall_cnt_o), 1);

    // Destination $zero never stalls
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk_out("zero", 1, 1, 0, 0, 0, 0);
    @(negedge clk_i);
    check("zero.cnt", 32'(stall_cnt_o), 1);

    // Load-use (on rt) outranks a taken branch
    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
    chk_out("br_lu", 0, 0, 0, 1, 0, 0);
    @(negedge clk_i);
    check("br_lu.cnt", 32'(stall_cnt_o), 2);
    drive(1'b0, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
    chk_out("br", 1, 1, 1, 0, 0, 0);
    @(negedge clk_i);
    check("br.cnt", 32'(stall_cnt_o), 2);

    // Memory wait: 3 cycles without ack, load-use also present
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    chk_out("mw0", 0, 0, 0, 0, 1, 1);
    @(negedge clk_i);
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
    chk_out("mw1", 0, 0, 0, 0, 1, 1);
    @(negedge clk_i);
    chk_out("mw2", 0, 0, 0, 0, 1, 1);
    @(negedge clk_i);
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1);
    chk_out("mw_ack", 0, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    check("mw.cnt", 32'(stall_cnt_o), 6);
    check("mw.timeout", 32'(timeout_o), 0);
    idle();
    chk_out("mw_back", 1, 1, 0, 0, 0, 0);
    @(negedge clk_i);

    // Zero-wait access
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk_out("zw", 1, 1, 0, 0, 0, 1);
    @(negedge clk_i);
    check("zw.cnt", 32'(stall_cnt_o), 6);

    // Timeout: ack never arrives
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("to%0d", i), 0, 0, 0, 0, 1, 1);
      check($sformatf("to%0d.timeout", i), 32'(timeout_o), 0);
      @(negedge clk_i);
    end
    check("err.timeout", 32'(timeout_o), 1);
    check("err.cnt", 32'(stall_cnt_o), 10);
    chk_out("err", 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) @(negedge clk_i);
    check("sat.cnt5", 32'(stall_cnt_o), 15);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk_out("err_ack", 0, 0, 0, 0, 1, 0);
    @(negedge clk_i);
    check("sat.cnt6", 32'(stall_cnt_o), 15);
    check("err_ack.timeout", 32'(timeout_o), 1);

    // Mid-cycle reset out of ERROR
    #2;
    rst_i = 1'b0;
    #1;
    chk_out("rst_err", 0, 0, 0, 1, 0, 0);
    check("rst_err.timeout", 32'(timeout_o), 0);
    check("rst_err.cnt", 32'(stall_cnt_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    idle();
    chk_out("post_rst", 1, 1, 0, 0, 0, 0);
    @(negedge clk_i);

    // Reset in the middle of MEM_WAIT aborts the request
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    chk_out("mw_pre", 0, 0, 0, 0, 1, 1);
    #1;
    rst_i = 1'b0;
    #1;
    chk_out("rst_mw", 0, 0, 0, 1, 0, 0);
    check("rst_mw.cnt", 32'(stall_cnt_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    idle();
    chk_out("rst_mw_run", 1, 1, 0, 0, 0, 0);
    @(negedge clk_i);
    check("rst_mw_run.cnt", 32'(stall_cnt_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Decides each cycle whether the PC and IF/ID advance, stall or flush, and whether the ID/EX register captures a bubble.
- Freezes all inter-stage registers (ID/EX, EX/MEM, MEM/WB) while a multi-cycle data-memory access is outstanding, with a timeout trap.
- Exports a saturating stall-cycle counter for performance debug.

Parameters:
CNT_W, 16, width of stall-cycle counter stall_cnt_o
MEM_TIMEOUT, 64, max cycles in MEM_WAIT before trapping to ERROR (>=2)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous, active-low reset
idex_memread_i  input  1  instruction in ID/EX is a load (M control bit)
idex_rt_i  input  5  destination rt of instruction in ID/EX
ifid_rs_i  input  5  rs field of instruction in IF/ID
ifid_rt_i  input  5  rt field of instruction in IF/ID
branch_taken_i  input  1  branch in ID resolved taken this cycle
exmem_memaccess_i  input  1  instruction in EX/MEM performs load or store
mem_ack_i  input  1  data memory completes the access this cycle
pc_write_o  output  1  PC register load enable
ifid_write_o  output  1  IF/ID load enable
ifid_flush_o  output  1  IF/ID loads NOP next edge
idex_bubble_o  output  1  ID/EX captures zero WB/M/EX controls next edge
pipe_hold_o  output  1  ID/EX, EX/MEM, MEM/WB hold current contents
mem_req_o  output  1  data-memory access request
timeout_o  output  1  sticky memory-timeout flag
stall_cnt_o  output  CNT_W  count of cycles with pc_write_o=0, saturating

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Registered: state, wait_cnt (clog2(MEM_TIMEOUT) bits), stall_cnt, timeout flag. All outputs otherwise Mealy-decoded from state + inputs, no added latency.
- rst_i low (asynchronous): state=RUN, wait_cnt=0, stall_cnt_o=0, timeout_o=0. While low, outputs forced: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=1, pipe_hold_o=0, mem_req_o=0. Reset mid-MEM_WAIT aborts the access; mem_req_o drops immediately.
- load_use = idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
- mem_stall = exmem_memaccess_i & ~mem_ack_i.
- RUN, priority high to low:
  - mem_stall: mem_req_o=1, pipe_hold_o=1, pc_write_o=0, ifid_write_o=0, idex_bubble_o=0, ifid_flush_o=0. Next state MEM_WAIT, wait_cnt<=1.
  - load_use: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0 (branch in ID is re-evaluated next cycle). mem_req_o=exmem_memaccess_i. Stay in RUN; hazard clears once the bubble reaches ID/EX.
  - branch_taken_i: ifid_flush_o=1, pc_write_o=1, ifid_write_o=1.
  - else: pc_write_o=1, ifid_write_o=1, all others 0, mem_req_o=exmem_memaccess_i.
  - A zero-wait access (ack in the same cycle as memaccess) causes no stall.
- MEM_WAIT:
  - mem_req_o=1 and pc_write_o=0, ifid_write_o=0; idex_bubble_o=0, ifid_flush_o=0.
  - ~mem_ack_i: pipe_hold_o=1.
  - mem_ack_i: pipe_hold_o=0, pc_write_o=0, ifid_write_o=0 this cycle, so the back end advances once while front-end hazard inputs are ignored. Next state RUN.
  - No ack and wait_cnt==MEM_TIMEOUT-1: next state ERROR. Else wait_cnt+1.
- ERROR: pipe_hold_o=1, pc_write_o=0, ifid_write_o=0, mem_req_o=0, timeout_o=1. Exit only via reset.
- stall_cnt_o increments each cycle pc_write_o=0 (reset excluded) and saturates at 2^CNT_W-1.

Test Plan:
- Load-use: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 for one cycle, then memread=0 -> pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for exactly 1 cycle; stall_cnt_o 0->1.
- $zero guard: idex_memread_i=1, idex_rt_i=0, ifid_rt_i=0 -> no stall, pc_write_o=1.
- Branch vs load-use: branch_taken_i=1 with load_use true -> ifid_flush_o=0, bubble=1; next cycle branch_taken_i=1 alone -> ifid_flush_o=1, pc_write_o=1.
- Memory wait: exmem_memaccess_i=1, mem_ack_i low 3 cycles then high -> pipe_hold_o=1 for 3 cycles, 0 on ack cycle; mem_req_o=1 for 4 cycles; state back to RUN; stall_cnt_o=4.
- Timeout and reset: MEM_TIMEOUT=4, ack never -> timeout_o=1 after 4 cycles, hold stuck at 1. Pull rst_i low mid-clock -> outputs drop to reset values immediately, timeout_o=0.
